// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and RAM-side signals of the two-port RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the view of whoever
// drives the requests and models the RAM.
interface mem_arbiter_if;
  // Requester side
  logic [1:0] req;
  logic [1:0] lock;
  logic [1:0] we;
  logic [7:0] addr0;
  logic [7:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [1:0] gnt;
  logic [1:0] ack;
  logic [7:0] rdata;
  // RAM side
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport slave (
    input  req, lock, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, lock, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 8-bit RAM port between the CPU (port 0) and a loader/DMA
// requester (port 1). Accesses are serialised through IDLE -> ISSUE -> [WAIT] -> ACK,
// with round-robin arbitration on contention.
//
// Optional feature: define MEM_ARB_LOCK_EN to let a port holding req+lock chain up to
// MAX_BURST accesses straight from ACK back to ISSUE without an IDLE gap. Without the
// macro the lock inputs are ignored.
//
// A read always spends RD_LAT cycles in WAIT: RAM data becomes valid RD_LAT cycles
// after the mem_en cycle, i.e. in the last WAIT cycle, and is registered into rdata on
// the edge leaving it. This gives ack in cycle 1+RD_LAT+1 after the request cycle.
module mem_arbiter #(
  parameter int unsigned RD_LAT    = 1,  // 1..3
  parameter int unsigned MAX_BURST = 4   // 1..15
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  localparam logic [1:0] WaitLast = 2'(RD_LAT - 1);

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       last_q, last_d;    // port served most recently
  logic [3:0] burst_q, burst_d;  // chained accesses in the current locked burst
  logic [1:0] wait_q, wait_d;    // read latency counter

  logic       win;       // arbitration winner in IDLE
  logic       gp;        // currently granted port
  logic       cap_port;  // port whose command is captured on this edge
  logic       cap_we;
  logic [7:0] cap_addr;
  logic [7:0] cap_wdata;
  logic       chain;     // stay with the granted port for another access

  assign gp = gnt_q[1];

  // Round-robin winner: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    if (bus.req == 2'b11) begin
      win = ~last_q;
    end else begin
      win = bus.req[1];
    end
  end

  // Command source: the arbitration winner from IDLE, or the same port when chaining.
  always_comb begin
    cap_port  = (state_q == StAck) ? gp : win;
    cap_we    = bus.we[cap_port];
    cap_addr  = cap_port ? bus.addr1 : bus.addr0;
    cap_wdata = cap_port ? bus.wdata1 : bus.wdata0;
  end

`ifdef MEM_ARB_LOCK_EN
  localparam logic [3:0] BurstLast = 4'(MAX_BURST - 1);

  // Chain only while the granted port keeps req+lock and has burst budget left.
  always_comb begin
    chain = bus.req[gp] & bus.lock[gp] & (burst_q < BurstLast);
  end
`else
  logic unused_lock;

  // Lock is ignored in this build; every access returns through IDLE.
  always_comb begin
    chain = 1'b0;
  end
  assign unused_lock = ^{bus.lock, burst_q};
`endif

  // Next-state and datapath updates of the access sequencer.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    last_d  = last_q;
    burst_d = burst_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        burst_d = '0;
        if (|bus.req) begin
          state_d = StIssue;
          gnt_d   = cap_port ? 2'b10 : 2'b01;
          we_d    = cap_we;
          addr_d  = cap_addr;
          wdata_d = cap_wdata;
        end
      end
      StIssue: begin
        wait_d  = '0;
        state_d = we_q ? StAck : StWait;
      end
      StWait: begin
        wait_d = wait_q + 2'd1;
        if (wait_q == WaitLast) begin
          rdata_d = bus.mem_rdata;
          state_d = StAck;
        end
      end
      StAck: begin
        last_d = gp;
        if (chain) begin
          state_d = StIssue;
          burst_d = burst_q + 4'd1;
          we_d    = cap_we;
          addr_d  = cap_addr;
          wdata_d = cap_wdata;
        end else begin
          state_d = StIdle;
          gnt_d   = '0;
          burst_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; an asynchronous reset drops any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      last_q  <= 1'b1;
      burst_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs: the command registers drive the RAM directly and hold between accesses.
  assign bus.gnt       = gnt_q;
  assign bus.ack       = (state_q == StAck) ? gnt_q : 2'b00;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = (state_q == StIssue);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Two instances share clk/reset:
// u_dut1 with RD_LAT=1 and u_dut3 with RD_LAT=3, each with its own RAM model.
// Cycle numbering: inputs are driven 1ns after an edge (cycle 0), outputs are sampled
// 1ns after later edges.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_arbiter_if bus1 ();
  mem_arbiter_if bus3 ();

  mem_arbiter #(.RD_LAT(1), .MAX_BURST(4)) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  mem_arbiter #(.RD_LAT(3), .MAX_BURST(4)) u_dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus3)
  );

  // RAM models: data valid RD_LAT cycles after the mem_en cycle, garbage otherwise.
  logic [7:0] ram1 [256];
  logic [7:0] ram3 [256];
  logic [7:0] rd1_q;
  logic [7:0] rd3_q [3];

  always @(posedge clk) begin
    if (!reset) begin
      ram1[8'h10] <= 8'h5A;
    end else if (bus1.mem_en && bus1.mem_we) begin
      ram1[bus1.mem_addr] <= bus1.mem_wdata;
    end
    rd1_q <= bus1.mem_en ? ram1[bus1.mem_addr] : 8'hEE;
  end
  assign bus1.mem_rdata = rd1_q;

  always @(posedge clk) begin
    if (!reset) begin
      ram3[8'h20] <= 8'h77;
    end else if (bus3.mem_en && bus3.mem_we) begin
      ram3[bus3.mem_addr] <= bus3.mem_wdata;
    end
    rd3_q[0] <= bus3.mem_en ? ram3[bus3.mem_addr] : 8'hEE;
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign bus3.mem_rdata = rd3_q[2];

  int unsigned n_asrt = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    bus1.req    = 2'b00;
    bus1.lock   = 2'b00;
    bus1.we     = 2'b00;
    bus1.addr0  = 8'h00;
    bus1.addr1  = 8'h00;
    bus1.wdata0 = 8'h00;
    bus1.wdata1 = 8'h00;
    bus3.req    = 2'b00;
    bus3.lock   = 2'b00;
    bus3.we     = 2'b00;
    bus3.addr0  = 8'h00;
    bus3.addr1  = 8'h00;
    bus3.wdata0 = 8'h00;
    bus3.wdata1 = 8'h00;
    step();
    step();

    // Reset state
    check("rst_gnt", 16'(bus1.gnt), 16'h0);
    check("rst_ack", 16'(bus1.ack), 16'h0);
    check("rst_mem_en", 16'(bus1.mem_en), 16'h0);
    check("rst_mem_we", 16'(bus1.mem_we), 16'h0);
    check("rst_rdata", 16'(bus1.rdata), 16'h0);
    check("rst_mem_addr", 16'(bus1.mem_addr), 16'h0);
    check("rst_mem_wdata", 16'(bus1.mem_wdata), 16'h0);
    reset = 1'b1;
    step();

    // Port-0 read of 0x10 (RAM 0x5A), RD_LAT=1: ack in cycle 3
    bus1.req   = 2'b01;
    bus1.we    = 2'b00;
    bus1.addr0 = 8'h10;
    step();
    check("rd_c1_gnt", 16'(bus1.gnt), 16'h1);
    check("rd_c1_mem_en", 16'(bus1.mem_en), 16'h1);
    check("rd_c1_mem_addr", 16'(bus1.mem_addr), 16'h10);
    check("rd_c1_mem_we", 16'(bus1.mem_we), 16'h0);
    bus1.req = 2'b00;
    step();
    check("rd_c2_ack", 16'(bus1.ack), 16'h0);
    check("rd_c2_mem_en", 16'(bus1.mem_en), 16'h0);
    check("rd_c2_gnt", 16'(bus1.gnt), 16'h1);
    step();
    check("rd_c3_ack", 16'(bus1.ack), 16'h1);
    check("rd_c3_rdata", 16'(bus1.rdata), 16'h5A);
    check("rd_c3_gnt", 16'(bus1.gnt), 16'h1);
    step();
    check("rd_c4_gnt", 16'(bus1.gnt), 16'h0);
    check("rd_c4_ack", 16'(bus1.ack), 16'h0);

    // Port-1 write 0xC3 to 0x80, req dropped and addr changed after grant
    bus1.req    = 2'b10;
    bus1.we     = 2'b10;
    bus1.addr1  = 8'h80;
    bus1.wdata1 = 8'hC3;
    step();
    check("wr1_c1_gnt", 16'(bus1.gnt), 16'h2);
    check("wr1_c1_mem_en", 16'(bus1.mem_en), 16'h1);
    check("wr1_c1_mem_we", 16'(bus1.mem_we), 16'h1);
    check("wr1_c1_mem_addr", 16'(bus1.mem_addr), 16'h80);
    check("wr1_c1_mem_wdata", 16'(bus1.mem_wdata), 16'hC3);
    bus1.req   = 2'b00;
    bus1.addr1 = 8'h99;
    step();
    check("wr1_c2_ack", 16'(bus1.ack), 16'h2);
    check("wr1_c2_ram", 16'(ram1[8'h80]), 16'hC3);
    check("wr1_c2_mem_addr_held", 16'(bus1.mem_addr), 16'h80);
    step();
    check("wr1_c3_gnt", 16'(bus1.gnt), 16'h0);
    check("wr1_c3_rdata_kept", 16'(bus1.rdata), 16'h5A);

    // Continuous contention of writes: grants alternate 0,1,0,1
    bus1.req    = 2'b11;
    bus1.we     = 2'b11;
    bus1.addr0  = 8'h01;
    bus1.addr1  = 8'h02;
    bus1.wdata0 = 8'hA0;
    bus1.wdata1 = 8'hB1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_issue_gnt", 16'(bus1.gnt), (i % 2 == 0) ? 16'h1 : 16'h2);
      check("rr_issue_mem_en", 16'(bus1.mem_en), 16'h1);
      check("rr_issue_mem_addr", 16'(bus1.mem_addr), (i % 2 == 0) ? 16'h01 : 16'h02);
      step();
      check("rr_ack", 16'(bus1.ack), (i % 2 == 0) ? 16'h1 : 16'h2);
      check("rr_ack_mem_en", 16'(bus1.mem_en), 16'h0);
      if (i == 3) bus1.req = 2'b00;
      step();
      check("rr_idle_gnt", 16'(bus1.gnt), 16'h0);
      check("rr_idle_mem_en", 16'(bus1.mem_en), 16'h0);
    end
    check("rr_ram_01", 16'(ram1[8'h01]), 16'hA0);
    check("rr_ram_02", 16'(ram1[8'h02]), 16'hB1);

    // RD_LAT=3 read of 0x20 (RAM 0x77): ack in cycle 5, then a write leaves rdata alone
    bus3.req   = 2'b01;
    bus3.we    = 2'b00;
    bus3.addr0 = 8'h20;
    step();
    check("rd3_c1_mem_en", 16'(bus3.mem_en), 16'h1);
    check("rd3_c1_gnt", 16'(bus3.gnt), 16'h1);
    bus3.req = 2'b00;
    for (int c = 2; c <= 4; c++) begin
      step();
      check("rd3_wait_ack", 16'(bus3.ack), 16'h0);
      check("rd3_wait_mem_en", 16'(bus3.mem_en), 16'h0);
    end
    step();
    check("rd3_c5_ack", 16'(bus3.ack), 16'h1);
    check("rd3_c5_rdata", 16'(bus3.rdata), 16'h77);
    step();
    check("rd3_c6_gnt", 16'(bus3.gnt), 16'h0);
    bus3.req    = 2'b01;
    bus3.we     = 2'b01;
    bus3.addr0  = 8'h21;
    bus3.wdata0 = 8'h11;
    step();
    bus3.req = 2'b00;
    step();
    check("wr3_ack", 16'(bus3.ack), 16'h1);
    check("wr3_rdata_kept", 16'(bus3.rdata), 16'h77);
    step();

    // Reset during WAIT: everything clears at once, no ack afterwards
    bus3.req   = 2'b01;
    bus3.we    = 2'b00;
    bus3.addr0 = 8'h20;
    step();
    bus3.req = 2'b00;
    step();
    check("rstw_pre_gnt", 16'(bus3.gnt), 16'h1);
    #2;
    reset = 1'b0;
    #1;
    check("rstw_gnt", 16'(bus3.gnt), 16'h0);
    check("rstw_ack", 16'(bus3.ack), 16'h0);
    check("rstw_mem_en", 16'(bus3.mem_en), 16'h0);
    check("rstw_rdata", 16'(bus3.rdata), 16'h0);
    check("rstw_mem_we", 16'(bus3.mem_we), 16'h0);
    step();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("rstw_no_ack", 16'(bus3.ack), 16'h0);
    end
    bus3.req   = 2'b11;
    bus3.we    = 2'b11;
    bus3.addr0 = 8'h30;
    bus3.addr1 = 8'h31;
    step();
    check("rstw_tie_gnt", 16'(bus3.gnt), 16'h1);
    check("rstw_tie_addr", 16'(bus3.mem_addr), 16'h30);
    bus3.req = 2'b00;
    step();
    check("rstw_tie_ack", 16'(bus3.ack), 16'h1);
    step();

    // Port 1 holds lock+req, port 0 joins one cycle later
    bus1.req    = 2'b10;
    bus1.lock   = 2'b10;
    bus1.we     = 2'b11;
    bus1.addr1  = 8'h40;
    bus1.wdata1 = 8'hD0;
    bus1.addr0  = 8'h50;
    bus1.wdata0 = 8'hE0;
    step();
`ifdef MEM_ARB_LOCK_EN
    for (int k = 0; k < 4; k++) begin
      check("lk_issue_gnt", 16'(bus1.gnt), 16'h2);
      check("lk_issue_mem_en", 16'(bus1.mem_en), 16'h1);
      check("lk_issue_addr", 16'(bus1.mem_addr), 16'(8'h40 + k));
      bus1.req = 2'b11;
      step();
      check("lk_ack", 16'(bus1.ack), 16'h2);
      check("lk_ack_gnt", 16'(bus1.gnt), 16'h2);
      check("lk_ack_mem_en", 16'(bus1.mem_en), 16'h0);
      bus1.addr1 = 8'(8'h41 + k);
      step();
    end
    check("lk_idle_gnt", 16'(bus1.gnt), 16'h0);
    check("lk_idle_mem_en", 16'(bus1.mem_en), 16'h0);
    step();
`else
    check("nl_c1_gnt", 16'(bus1.gnt), 16'h2);
    check("nl_c1_addr", 16'(bus1.mem_addr), 16'h40);
    bus1.req = 2'b11;
    step();
    check("nl_c2_ack", 16'(bus1.ack), 16'h2);
    step();
    check("nl_c3_gnt", 16'(bus1.gnt), 16'h0);
    step();
`endif
    check("p0_after_gnt", 16'(bus1.gnt), 16'h1);
    check("p0_after_addr", 16'(bus1.mem_addr), 16'h50);
    bus1.req  = 2'b00;
    bus1.lock = 2'b00;
    step();
    check("p0_after_ack", 16'(bus1.ack), 16'h1);
    step();
    check("p0_after_idle", 16'(bus1.gnt), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
